// File: rtl/uart_poll_pkg.sv
// uart_poll_pkg
// Shared definitions for the polled UART: TX/RX state encodings, bit
// positions inside the status register, the baud counter type and the
// divider computation used by both the transmitter and the receiver.
package uart_poll_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Bit positions inside the status/control read value (bit 5 reads 0).
    localparam logic [2:0] ST_RX_READY  = 3'd0;
    localparam logic [2:0] ST_THR_EMPTY = 3'd1;
    localparam logic [2:0] ST_RX_OVR    = 3'd2;
    localparam logic [2:0] ST_FERR      = 3'd3;
    localparam logic [2:0] ST_TX_BUSY   = 3'd4;
    localparam logic [2:0] ST_TX_OVR    = 3'd6;
    localparam logic [2:0] ST_IE        = 3'd7;

    localparam int unsigned CNT_W = 16;
    typedef logic [CNT_W-1:0] baud_cnt_t;

    // Clocks per bit period, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_poll_if.sv
// uart_poll_if
// CPU-side register bus of the polled UART.
//   cpu_en : one-clock strobe per CPU clock, qualifies bus sampling
//   cs     : decoded I/O select
//   a0     : register select (0 = data, 1 = status/control)
//   n_rd   : read, active-low
//   n_wr   : write, active-low
//   din    : write data
//   dout   : read data (combinational from a0)
interface uart_poll_if;
    logic       cpu_en;
    logic       cs;
    logic       a0;
    logic       n_rd;
    logic       n_wr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cpu_en, cs, a0, n_rd, n_wr, din, input dout);
    modport slave  (input cpu_en, cs, a0, n_rd, n_wr, din, output dout);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Receive path: two-flop synchroniser on rxd, start-bit glitch rejection,
// LSB-first shift register and stop-bit check.
//   CLK50MHz  : system clock
//   nRESET    : synchronous active-low reset
//   rxd       : asynchronous serial input, idle high
//   rx_done_s : one-clock strobe, stop bit sampled high (rx_byte_r valid)
//   rx_ferr_s : one-clock strobe, stop bit sampled low
//   rx_byte_r : received byte
module uart_rx_core
    import uart_poll_pkg::*;
#(
    parameter int unsigned DIV = 434
)(
    input  logic       CLK50MHz,
    input  logic       nRESET,
    input  logic       rxd,
    output logic       rx_done_s,
    output logic       rx_ferr_s,
    output logic [7:0] rx_byte_r
);

    localparam baud_cnt_t DIV_LAST = baud_cnt_t'(DIV - 32'd1);
    localparam baud_cnt_t DIV_HALF = baud_cnt_t'(DIV / 32'd2);

    logic      rxd_meta_r;
    logic      rxd_sync_r;
    rx_state_e rx_state_r;
    baud_cnt_t rx_cnt_r;
    logic [2:0] rx_bit_r;
    logic      rx_tick_s;

    assign rx_tick_s = (rx_cnt_r == DIV_LAST);

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Receive state machine, bit timer and shift register.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_byte_r  <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= 3'd0;
                    if (!rxd_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the line mid start bit; a short low pulse is ignored.
                    if (rx_cnt_r == DIV_HALF) begin
                        rx_cnt_r <= '0;
                        if (rxd_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick_s) begin
                        rx_cnt_r  <= '0;
                        rx_byte_r <= {rxd_sync_r, rx_byte_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick_s) begin
                        rx_cnt_r <= '0;
                        if (rxd_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Hold off until the line returns to idle after a bad stop bit.
                    rx_cnt_r <= '0;
                    if (rxd_sync_r) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= '0;
                end
            endcase
        end
    end

    // Completion strobes, valid on the edge where the stop bit is sampled.
    always_comb begin
        rx_done_s = 1'b0;
        rx_ferr_s = 1'b0;
        if ((rx_state_r == RX_STOP) && rx_tick_s) begin
            rx_done_s = rxd_sync_r;
            rx_ferr_s = ~rxd_sync_r;
        end else begin
            rx_done_s = 1'b0;
            rx_ferr_s = 1'b0;
        end
    end

endmodule

// File: rtl/uart_poll.sv
// uart_poll
// Polled 8N1 UART with a one-byte transmit holding register, one-byte
// receive buffer and a level interrupt on received data.
//   CLK50MHz : system clock
//   nRESET   : synchronous active-low reset
//   bus      : CPU register bus (uart_poll_if.slave)
//   rxd      : serial input, asynchronous, idle high
//   txd      : serial output, idle high (registered)
//   rx_irq   : rx_ready & ie, registered
module uart_poll
    import uart_poll_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
)(
    input  logic       CLK50MHz,
    input  logic       nRESET,
    uart_poll_if.slave bus,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_irq
);

    localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
    localparam baud_cnt_t   DIV_LAST = baud_cnt_t'(DIV - 32'd1);

    // Bus access tracking
    logic wr_done_r, rd_seen_r, rd_a0_r;
    logic wr_act_s, wr_fire_s, rd_act_s, rd_end_s;
    logic data_wr_s, ctrl_wr_s, data_rd_end_s, stat_rd_end_s;

    // Registers
    logic [7:0] thr_r, rbr_r;
    logic       thr_full_r, tx_ovr_r, ie_r;
    logic       rx_ready_r, rx_ovr_r, ferr_r, rx_irq_r;
    logic [7:0] status_s;

    // Transmitter
    tx_state_e  tx_state_r;
    baud_cnt_t  tx_cnt_r;
    logic [2:0] tx_bit_r;
    logic [7:0] tx_shift_r;
    logic       txd_r;
    logic       tx_tick_s, tx_load_s, tx_busy_s;

    // Receiver
    logic       rx_done_s, rx_ferr_s;
    logic [7:0] rx_byte_s;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .CLK50MHz (CLK50MHz),
        .nRESET   (nRESET),
        .rxd      (rxd),
        .rx_done_s(rx_done_s),
        .rx_ferr_s(rx_ferr_s),
        .rx_byte_r(rx_byte_s)
    );

    assign wr_act_s      = bus.cs & ~bus.n_wr;
    assign wr_fire_s     = wr_act_s & bus.cpu_en & ~wr_done_r;
    assign rd_act_s      = bus.cs & ~bus.n_rd;
    // A read completes on the first edge the strobe is gone after a sampled cpu_en.
    assign rd_end_s      = rd_seen_r & ~rd_act_s;
    assign data_wr_s     = wr_fire_s & ~bus.a0;
    assign ctrl_wr_s     = wr_fire_s & bus.a0;
    assign data_rd_end_s = rd_end_s & ~rd_a0_r;
    assign stat_rd_end_s = rd_end_s & rd_a0_r;

    assign tx_tick_s = (tx_cnt_r == DIV_LAST);
    assign tx_busy_s = (tx_state_r != TX_IDLE);
    // THR moves into the shifter from IDLE, or straight out of STOP for gapless frames.
    assign tx_load_s = thr_full_r &
                       ((tx_state_r == TX_IDLE) || ((tx_state_r == TX_STOP) && tx_tick_s));

    assign txd    = txd_r;
    assign rx_irq = rx_irq_r;

    // Access tracking: one write per access, read side effects deferred to access end.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            wr_done_r <= 1'b0;
            rd_seen_r <= 1'b0;
            rd_a0_r   <= 1'b0;
        end else begin
            if (!wr_act_s) begin
                wr_done_r <= 1'b0;
            end else if (bus.cpu_en) begin
                wr_done_r <= 1'b1;
            end
            if (!rd_act_s) begin
                rd_seen_r <= 1'b0;
            end else if (bus.cpu_en) begin
                rd_seen_r <= 1'b1;
                rd_a0_r   <= bus.a0;
            end
        end
    end

    // Transmit holding register, control register and TX overrun flag.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            thr_r      <= 8'h00;
            thr_full_r <= 1'b0;
            tx_ovr_r   <= 1'b0;
            ie_r       <= 1'b0;
        end else begin
            if (tx_load_s) begin
                thr_full_r <= 1'b0;
            end else if (data_wr_s) begin
                thr_full_r <= 1'b1;
            end
            if (data_wr_s && !thr_full_r) begin
                thr_r <= bus.din;
            end
            if (ctrl_wr_s) begin
                ie_r     <= bus.din[0];
                tx_ovr_r <= 1'b0;
            end else if (data_wr_s && thr_full_r) begin
                tx_ovr_r <= 1'b1;
            end
        end
    end

    // Receive buffer, receive status flags and interrupt output.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            rbr_r      <= 8'h00;
            rx_ready_r <= 1'b0;
            rx_ovr_r   <= 1'b0;
            ferr_r     <= 1'b0;
            rx_irq_r   <= 1'b0;
        end else begin
            if (rx_done_s) begin
                rbr_r <= rx_byte_s;
            end
            // A new byte beats a data read ending on the same edge.
            if (rx_done_s) begin
                rx_ready_r <= 1'b1;
            end else if (data_rd_end_s) begin
                rx_ready_r <= 1'b0;
            end
            // Overrun only if the old byte is still unread after this edge.
            if (rx_done_s && rx_ready_r && !data_rd_end_s) begin
                rx_ovr_r <= 1'b1;
            end else if (stat_rd_end_s) begin
                rx_ovr_r <= 1'b0;
            end
            if (rx_ferr_s) begin
                ferr_r <= 1'b1;
            end else if (stat_rd_end_s) begin
                ferr_r <= 1'b0;
            end
            rx_irq_r <= rx_ready_r & ie_r;
        end
    end

    // Transmit state machine; txd is registered alongside the state.
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= '0;
                    tx_bit_r <= 3'd0;
                    if (thr_full_r) begin
                        tx_shift_r <= thr_r;
                        tx_state_r <= TX_START;
                        txd_r      <= 1'b0;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_tick_s) begin
                        tx_cnt_r   <= '0;
                        tx_bit_r   <= 3'd0;
                        tx_state_r <= TX_DATA;
                        txd_r      <= tx_shift_r[0];
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick_s) begin
                        tx_cnt_r <= '0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= TX_STOP;
                            txd_r      <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            txd_r      <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick_s) begin
                        tx_cnt_r <= '0;
                        if (thr_full_r) begin
                            tx_shift_r <= thr_r;
                            tx_state_r <= TX_START;
                            txd_r      <= 1'b0;
                        end else begin
                            tx_state_r <= TX_IDLE;
                            txd_r      <= 1'b1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= '0;
                    txd_r      <= 1'b1;
                end
            endcase
        end
    end

    // Status assembly and read data mux.
    always_comb begin
        status_s               = 8'h00;
        status_s[ST_RX_READY]  = rx_ready_r;
        status_s[ST_THR_EMPTY] = ~thr_full_r;
        status_s[ST_RX_OVR]    = rx_ovr_r;
        status_s[ST_FERR]      = ferr_r;
        status_s[ST_TX_BUSY]   = tx_busy_s;
        status_s[ST_TX_OVR]    = tx_ovr_r;
        status_s[ST_IE]        = ie_r;
        bus.dout = 8'h00;
        if (bus.a0) begin
            bus.dout = status_s;
        end else begin
            bus.dout = rbr_r;
        end
    end

endmodule

// File: tb/tb_uart_poll.sv
// tb_uart_poll
// Directed bench for uart_poll at default parameters (DIV = 434).
module tb_uart_poll;

    localparam int DIV = 434;
    // Stop-bit sample edge counted from the negedge where a start bit is driven:
    // 1 edge into the first flop, 2 more to leave IDLE, DIV/2+1 in START, 9*DIV after.
    localparam int RX_DONE = 4127;

    logic CLK50MHz = 1'b0;
    logic nRESET   = 1'b0;
    logic rxd      = 1'b1;
    logic txd;
    logic rx_irq;

    int cyc    = 0;
    int wr_cyc = 0;
    int checks = 0;
    int errors = 0;

    uart_poll_if bus_if ();

    uart_poll dut (
        .CLK50MHz(CLK50MHz),
        .nRESET  (nRESET),
        .bus     (bus_if),
        .rxd     (rxd),
        .txd     (txd),
        .rx_irq  (rx_irq)
    );

    always #10 CLK50MHz = ~CLK50MHz;

    always @(posedge CLK50MHz) cyc <= cyc + 1;

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge CLK50MHz);
            #1;
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, input int pulses);
        @(negedge CLK50MHz);
        bus_if.cs = 1'b1; bus_if.a0 = a; bus_if.n_wr = 1'b0; bus_if.din = d; bus_if.cpu_en = 1'b1;
        @(posedge CLK50MHz);
        #1;
        wr_cyc = cyc;
        @(negedge CLK50MHz);
        bus_if.cpu_en = 1'b0;
        for (int i = 1; i < pulses; i++) begin
            @(negedge CLK50MHz);
            bus_if.cpu_en = 1'b1;
            @(negedge CLK50MHz);
            bus_if.cpu_en = 1'b0;
        end
        @(negedge CLK50MHz);
        bus_if.cs = 1'b0; bus_if.n_wr = 1'b1;
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        @(negedge CLK50MHz);
        bus_if.cs = 1'b1; bus_if.a0 = a; bus_if.n_rd = 1'b0; bus_if.cpu_en = 1'b1;
        @(negedge CLK50MHz);
        bus_if.cpu_en = 1'b0;
        d = bus_if.dout;
        @(negedge CLK50MHz);
        bus_if.cs = 1'b0; bus_if.n_rd = 1'b1;
        @(posedge CLK50MHz);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (DIV) @(negedge CLK50MHz);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        bus_if.cpu_en = 1'b0; bus_if.cs = 1'b0; bus_if.a0 = 1'b1;
        bus_if.n_rd = 1'b1; bus_if.n_wr = 1'b1; bus_if.din = 8'h00;
        nRESET = 1'b0;
        repeat (4) @(posedge CLK50MHz);
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
        checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", rx_irq); end
        @(negedge CLK50MHz);
        nRESET = 1'b1;
        @(posedge CLK50MHz);
        #1;
        checks++; if (bus_if.dout !== 8'h02) begin errors++; $display("FAIL reset_status got %h exp 02", bus_if.dout); end
        bus_if.a0 = 1'b0;
        #1;
        checks++; if (bus_if.dout !== 8'h00) begin errors++; $display("FAIL reset_rbr got %h exp 00", bus_if.dout); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        logic [7:0] st;
        int t0;
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(1'b0, 8'h55, 3);
        t0 = wr_cyc + 1;
        bus_read(1'b1, st);
        checks++; if (st !== 8'h12) begin errors++; $display("FAIL tx_load_status got %h exp 12", st); end
        wait_until(t0 + DIV - 1);
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_end got %b exp 0", txd); end
        for (int i = 0; i < 10; i++) begin
            wait_until(t0 + i * DIV + DIV / 2);
            checks++;
            if (txd !== frame[i]) begin errors++; $display("FAIL tx55_bit%0d got %b exp %b", i, txd, frame[i]); end
        end
        wait_until(t0 + 10 * DIV - 1);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_stop_end got %b exp 1", txd); end
        wait_until(t0 + 10 * DIV);
        bus_read(1'b1, st);
        checks++; if (st !== 8'h02) begin errors++; $display("FAIL tx_single_write got %h exp 02", st); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] fa, fb;
        logic [7:0] st;
        int t0;
        fa = {1'b1, 8'hA5, 1'b0};
        fb = {1'b1, 8'h3C, 1'b0};
        bus_write(1'b0, 8'hA5, 1);
        t0 = wr_cyc + 1;
        bus_write(1'b0, 8'h3C, 1);
        bus_write(1'b0, 8'h77, 1);
        bus_read(1'b1, st);
        checks++; if (st !== 8'h50) begin errors++; $display("FAIL b2b_ovr_status got %h exp 50", st); end
        for (int i = 0; i < 10; i++) begin
            wait_until(t0 + i * DIV + DIV / 2);
            checks++;
            if (txd !== fa[i]) begin errors++; $display("FAIL txA5_bit%0d got %b exp %b", i, txd, fa[i]); end
        end
        wait_until(t0 + 10 * DIV - 1);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_stop1 got %b exp 1", txd); end
        wait_until(t0 + 10 * DIV);
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got %b exp 0", txd); end
        for (int i = 0; i < 10; i++) begin
            wait_until(t0 + 10 * DIV + i * DIV + DIV / 2);
            checks++;
            if (txd !== fb[i]) begin errors++; $display("FAIL tx3C_bit%0d got %b exp %b", i, txd, fb[i]); end
        end
        wait_until(t0 + 20 * DIV);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", txd); end
        bus_read(1'b1, st);
        checks++; if (st !== 8'h42) begin errors++; $display("FAIL b2b_end_status got %h exp 42", st); end
        bus_write(1'b1, 8'h00, 1);
        bus_read(1'b1, st);
        checks++; if (st !== 8'h02) begin errors++; $display("FAIL ctrl_clear_ovr got %h exp 02", st); end
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        int c0;
        bus_write(1'b1, 8'h01, 1);
        bus_if.a0 = 1'b1;
        @(negedge CLK50MHz);
        c0 = cyc;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_until(c0 + RX_DONE - 1);
                checks++; if (bus_if.dout[0] !== 1'b0) begin errors++; $display("FAIL rx_ready_early got %b exp 0", bus_if.dout[0]); end
                wait_until(c0 + RX_DONE);
                checks++; if (bus_if.dout[0] !== 1'b1) begin errors++; $display("FAIL rx_ready_set got %b exp 1", bus_if.dout[0]); end
                checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_latency got %b exp 0", rx_irq); end
                wait_until(c0 + RX_DONE + 1);
                checks++; if (rx_irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got %b exp 1", rx_irq); end
            end
        join
        bus_read(1'b0, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rx_data got %h exp c3", d); end
        bus_if.a0 = 1'b1;
        #1;
        checks++; if (bus_if.dout[0] !== 1'b0) begin errors++; $display("FAIL rx_ready_clear got %b exp 0", bus_if.dout[0]); end
        @(posedge CLK50MHz);
        #1;
        checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got %b exp 0", rx_irq); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        @(negedge CLK50MHz);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (8) @(posedge CLK50MHz);
        #1;
        bus_if.a0 = 1'b1;
        #1;
        checks++; if (bus_if.dout !== 8'h87) begin errors++; $display("FAIL ovr_status got %h exp 87", bus_if.dout); end
        bus_read(1'b0, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL ovr_rbr got %h exp 22", d); end
        bus_read(1'b1, d);
        checks++; if (d !== 8'h86) begin errors++; $display("FAIL ovr_status_read got %h exp 86", d); end
        #1;
        checks++; if (bus_if.dout !== 8'h82) begin errors++; $display("FAIL ovr_cleared got %h exp 82", bus_if.dout); end
    endtask

    task automatic test_rx_framing();
        logic [7:0] d;
        @(negedge CLK50MHz);
        send_frame(8'h5A, 1'b0);
        repeat (8) @(posedge CLK50MHz);
        #1;
        bus_if.a0 = 1'b1;
        #1;
        checks++; if (bus_if.dout !== 8'h8A) begin errors++; $display("FAIL ferr_status got %h exp 8a", bus_if.dout); end
        checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL ferr_irq got %b exp 0", rx_irq); end
        bus_read(1'b1, d);
        #1;
        checks++; if (bus_if.dout !== 8'h82) begin errors++; $display("FAIL ferr_cleared got %h exp 82", bus_if.dout); end
        bus_read(1'b0, d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL ferr_rbr_kept got %h exp 22", d); end
        @(negedge CLK50MHz);
        rxd = 1'b0;
        repeat (100) @(negedge CLK50MHz);
        rxd = 1'b1;
        repeat (2 * DIV) @(posedge CLK50MHz);
        #1;
        bus_if.a0 = 1'b1;
        #1;
        checks++; if (bus_if.dout !== 8'h82) begin errors++; $display("FAIL glitch_reject got %h exp 82", bus_if.dout); end
    endtask

    task automatic test_reset_mid_tx();
        int t0;
        bus_write(1'b0, 8'h00, 1);
        t0 = wr_cyc + 1;
        wait_until(t0 + DIV + 20);
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL mid_tx_bit got %b exp 0", txd); end
        @(negedge CLK50MHz);
        nRESET = 1'b0;
        @(posedge CLK50MHz);
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd_edge got %b exp 1", txd); end
        repeat (3) @(posedge CLK50MHz);
        @(negedge CLK50MHz);
        nRESET = 1'b1;
        @(posedge CLK50MHz);
        #1;
        bus_if.a0 = 1'b1;
        #1;
        checks++; if (bus_if.dout !== 8'h02) begin errors++; $display("FAIL rst_status got %h exp 02", bus_if.dout); end
        checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", rx_irq); end
        bus_if.a0 = 1'b0;
        #1;
        checks++; if (bus_if.dout !== 8'h00) begin errors++; $display("FAIL rst_rbr got %h exp 00", bus_if.dout); end
        repeat (11 * DIV) @(posedge CLK50MHz);
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_frame_aborted got %b exp 1", txd); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_irq();
        test_rx_overrun();
        test_rx_framing();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
